// File: rtl/muldiv_div_arbiter.sv
// Round-robin arbiter that shares one unsigned iterative divider among N_REQ requesters,
// handling sign fix-up and the divide-by-zero / overflow cases. Optional macro: DIV_ARB_BYPASS_EN.
module muldiv_div_arbiter #(
  parameter int N_REQ = 4,
  parameter int ROB_W = 5
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        flush,
  input  logic [N_REQ-1:0]            req,
  input  logic [N_REQ-1:0][31:0]      req_a,
  input  logic [N_REQ-1:0][31:0]      req_b,
  input  logic [N_REQ-1:0][2:0]       req_funct3,
  input  logic [N_REQ-1:0][ROB_W-1:0] req_rob,
  output logic [N_REQ-1:0]            gnt,
  output logic                        div_start,
  output logic [31:0]                 div_a,
  output logic [31:0]                 div_b,
  output logic                        div_kill,
  input  logic                        div_complete,
  input  logic [31:0]                 div_quotient,
  input  logic [31:0]                 div_remainder,
  output logic                        resp_valid,
  output logic [ROB_W-1:0]            resp_rob,
  output logic [31:0]                 resp_data,
  input  logic                        resp_ready
);

  localparam int PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  typedef enum logic [1:0] {IDLE, START, WAIT, RESP} state_t;

  state_t             state, state_d;
  logic [PTR_W-1:0]   rr_ptr, winner, ptr_next, cand;
  logic               found, grant_fire;
  int                 idx;

  logic [31:0]        sel_a, sel_b;
  logic [2:0]         sel_f3;
  logic [ROB_W-1:0]   sel_rob;
  logic               is_signed, is_rem, a_neg, b_neg, q_neg;
  logic [31:0]        abs_a, abs_b;
  logic               skip;
  logic [31:0]        skip_res;

  logic [31:0]        op_a_q, op_b_q;
  logic               is_rem_q, q_neg_q, r_neg_q;
  logic [31:0]        raw_res, fixed_res;
  logic               res_neg;

  // Search for the first requester starting at the round-robin pointer
  always_comb begin
    winner = '0;
    found  = 1'b0;
    idx    = 0;
    cand   = '0;
    for (int k = 0; k < N_REQ; k++) begin
      idx = int'(rr_ptr) + k;
      if (idx >= N_REQ) idx = idx - N_REQ;
      cand = PTR_W'(idx);
      if (!found && req[cand]) begin
        found  = 1'b1;
        winner = cand;
      end
    end
  end

  assign ptr_next   = (winner == PTR_W'(N_REQ - 1)) ? '0 : winner + 1'b1;
  assign grant_fire = (state == IDLE) && found && !flush;

  assign sel_a   = req_a[winner];
  assign sel_b   = req_b[winner];
  assign sel_f3  = req_funct3[winner];
  assign sel_rob = req_rob[winner];

  assign is_signed = ~sel_f3[0];
  assign is_rem    = sel_f3[1];
  assign a_neg     = is_signed & sel_a[31];
  assign b_neg     = is_signed & sel_b[31];
  assign q_neg     = a_neg ^ b_neg;
  assign abs_a     = a_neg ? (~sel_a + 32'd1) : sel_a;
  assign abs_b     = b_neg ? (~sel_b + 32'd1) : sel_b;

  // Cases whose result is known at grant time and never reach the divider
  always_comb begin
    skip     = 1'b0;
    skip_res = '0;
    if (sel_b == 32'd0) begin
      skip     = 1'b1;
      skip_res = is_rem ? sel_a : 32'hFFFF_FFFF;
    end else if (is_signed && sel_a == 32'h8000_0000 && sel_b == 32'hFFFF_FFFF) begin
      skip     = 1'b1;
      skip_res = is_rem ? 32'd0 : 32'h8000_0000;
    end
`ifdef DIV_ARB_BYPASS_EN
    else if (abs_a < abs_b) begin
      skip     = 1'b1;
      skip_res = is_rem ? sel_a : 32'd0;
    end else if (abs_b == 32'd1) begin
      skip     = 1'b1;
      skip_res = is_rem ? 32'd0 : (q_neg ? (~abs_a + 32'd1) : abs_a);
    end else if (abs_a == abs_b) begin
      skip     = 1'b1;
      skip_res = is_rem ? 32'd0 : (q_neg ? 32'hFFFF_FFFF : 32'd1);
    end
`endif
  end

  assign raw_res   = is_rem_q ? div_remainder : div_quotient;
  assign res_neg   = is_rem_q ? r_neg_q : q_neg_q;
  assign fixed_res = res_neg ? (~raw_res + 32'd1) : raw_res;

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_d;
  end

  // Next state and handshake outputs; flush and reset abort whatever is in flight
  always_comb begin
    state_d    = state;
    gnt        = '0;
    div_start  = 1'b0;
    resp_valid = 1'b0;
    case (state)
      IDLE: begin
        if (grant_fire) begin
          gnt[winner] = 1'b1;
          state_d     = skip ? RESP : START;
        end
      end
      START: begin
        div_start = 1'b1;
        state_d   = WAIT;
      end
      WAIT: begin
        if (div_complete) state_d = RESP;
      end
      RESP: begin
        resp_valid = 1'b1;
        if (resp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    if (flush || rst) begin
      state_d    = IDLE;
      gnt        = '0;
      div_start  = 1'b0;
      resp_valid = 1'b0;
    end
  end

  assign div_kill = flush | rst;
  assign div_a    = op_a_q;
  assign div_b    = op_b_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      rr_ptr    <= '0;
      op_a_q    <= '0;
      op_b_q    <= '0;
      is_rem_q  <= 1'b0;
      q_neg_q   <= 1'b0;
      r_neg_q   <= 1'b0;
      resp_rob  <= '0;
      resp_data <= '0;
    end else begin
      if (grant_fire) begin
        rr_ptr   <= ptr_next;
        op_a_q   <= abs_a;
        op_b_q   <= abs_b;
        is_rem_q <= is_rem;
        q_neg_q  <= q_neg;
        r_neg_q  <= a_neg;
        resp_rob <= sel_rob;
        if (skip) resp_data <= skip_res;
      end
      if (state == WAIT && div_complete && !flush) resp_data <= fixed_res;
    end
  end

endmodule
